// File: rtl/iu_pkg.sv
// Shared types and helpers for the integer-pipeline hazard/forwarding tracker.
package iu_pkg;

   // Entry rn is sized for the largest supported register file; callers size-cast to it.
   localparam int IU_RN_W = 8;
   localparam int FWD_RF  = 0;

   typedef struct packed {
      logic               valid;
      logic               wreg;
      logic [IU_RN_W-1:0] rn;
      logic               load;
   } iu_entry_t;

   function automatic int iu_sel_w(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/iu_fwd_match.sv
// One source operand's priority search over the in-flight stage entries.
module iu_fwd_match
   import iu_pkg::*;
#(
   parameter int STAGES     = 2,
   parameter int LOAD_STAGE = 2,
   parameter int AW         = 5,
   parameter int SW         = 2
) (
   input  iu_entry_t [STAGES-1:0] entries_i,
   input  logic                   en_i,
   input  logic [AW-1:0]          rs_i,
   output logic                   hit_o,
   output logic [SW-1:0]          sel_o,
   output logic                   mem_o,
   output logic                   hazard_o
);

   always_comb begin
      hit_o    = 1'b0;
      sel_o    = SW'(FWD_RF);
      mem_o    = 1'b0;
      hazard_o = 1'b0;
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int k = STAGES; k >= 1; k--) begin
         if (en_i && entries_i[k-1].valid && entries_i[k-1].wreg &&
             entries_i[k-1].rn == IU_RN_W'(rs_i)) begin
            hit_o    = 1'b1;
            sel_o    = SW'(k);
            mem_o    = entries_i[k-1].load;
            hazard_o = entries_i[k-1].load && (k < LOAD_STAGE);
         end
      end
   end

endmodule

// File: rtl/iu_hazard_unit.sv
// Tracks destinations in flight past ID; drives operand forwarding selects,
// the load-use stall, retire info and a saturating stall counter.
module iu_hazard_unit
   import iu_pkg::*;
#(
   parameter int  NREG       = 32,
   parameter int  STAGES     = 2,
   parameter int  LOAD_STAGE = 2,
   parameter int  NSRC       = 2,
   parameter int  SW         = iu_sel_w(STAGES),
   localparam int AW         = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               id_valid,
   input  logic [NSRC*AW-1:0] id_rs,
   input  logic [NSRC-1:0]    id_use,
   input  logic               id_wreg,
   input  logic [AW-1:0]      id_rn,
   input  logic               id_load,
   input  logic               flush,
   input  logic               ext_stall,
   output logic               stall,
   output logic [NSRC*SW-1:0] fwd_sel,
   output logic [NSRC-1:0]    fwd_mem,
   output logic [STAGES-1:0]  stg_valid,
   output logic               ret_valid,
   output logic [AW-1:0]      ret_rn,
   output logic [15:0]        stall_cnt
);

   iu_entry_t [STAGES-1:0] entries_q, entries_d;
   iu_entry_t              id_entry;
   logic [15:0]            stall_cnt_q, stall_cnt_d;
   logic [NSRC-1:0]        hit, mem_raw, hazard;
   logic                   accept;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         iu_fwd_match #(
            .STAGES     (STAGES),
            .LOAD_STAGE (LOAD_STAGE),
            .AW         (AW),
            .SW         (SW)
         ) u_match (
            .entries_i (entries_q),
            .en_i      (id_valid & id_use[gi] & (id_rs[gi*AW +: AW] != '0)),
            .rs_i      (id_rs[gi*AW +: AW]),
            .hit_o     (hit[gi]),
            .sel_o     (fwd_sel[gi*SW +: SW]),
            .mem_o     (mem_raw[gi]),
            .hazard_o  (hazard[gi])
         );
         assign fwd_mem[gi] = hit[gi] & mem_raw[gi];
      end

      for (gi = 0; gi < STAGES; gi++) begin : g_vld
         assign stg_valid[gi] = entries_q[gi].valid;
      end
   endgenerate

   assign stall  = (|hazard) & ~flush;
   assign accept = id_valid & ~stall & ~flush;

   always_comb begin
      id_entry = '0;
      if (accept) begin
         id_entry.valid = 1'b1;
         id_entry.wreg  = id_wreg;
         id_entry.rn    = IU_RN_W'(id_rn);
         id_entry.load  = id_load;
      end
   end

   always_comb begin
      entries_d    = entries_q;
      entries_d[0] = id_entry;
      for (int k = 1; k < STAGES; k++) begin
         entries_d[k] = entries_q[k-1];
      end
   end

   assign stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         entries_q   <= '0;
         stall_cnt_q <= '0;
      end else if (!ext_stall) begin
         entries_q   <= entries_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // The register file writes on negedge, so the final entry is the last one forwarded.
   assign ret_valid = entries_q[STAGES-1].valid & entries_q[STAGES-1].wreg & ~ext_stall;
   assign ret_rn    = entries_q[STAGES-1].rn[AW-1:0];
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_iu_hazard_unit.sv
// Directed plus randomized bench for iu_hazard_unit against an in-flight instruction list.
module tb_iu_hazard_unit;

   localparam int NREG = 32;
   localparam int STAGES = 2;
   localparam int LOAD_STAGE = 2;
   localparam int NSRC = 2;
   localparam int SW = 2;
   localparam int AW = 5;

   logic               clk = 1'b0;
   logic               clrn;
   logic               id_valid;
   logic [NSRC*AW-1:0] id_rs;
   logic [NSRC-1:0]    id_use;
   logic               id_wreg;
   logic [AW-1:0]      id_rn;
   logic               id_load;
   logic               flush;
   logic               ext_stall;
   logic               stall;
   logic [NSRC*SW-1:0] fwd_sel;
   logic [NSRC-1:0]    fwd_mem;
   logic [STAGES-1:0]  stg_valid;
   logic               ret_valid;
   logic [AW-1:0]      ret_rn;
   logic [15:0]        stall_cnt;

   iu_hazard_unit #(
      .NREG       (NREG),
      .STAGES     (STAGES),
      .LOAD_STAGE (LOAD_STAGE),
      .NSRC       (NSRC)
   ) dut (
      .clk       (clk),
      .clrn      (clrn),
      .id_valid  (id_valid),
      .id_rs     (id_rs),
      .id_use    (id_use),
      .id_wreg   (id_wreg),
      .id_rn     (id_rn),
      .id_load   (id_load),
      .flush     (flush),
      .ext_stall (ext_stall),
      .stall     (stall),
      .fwd_sel   (fwd_sel),
      .fwd_mem   (fwd_mem),
      .stg_valid (stg_valid),
      .ret_valid (ret_valid),
      .ret_rn    (ret_rn),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference: instructions in flight, index 1 = one stage past ID.
   int inf_valid[1:STAGES];
   int inf_wreg [1:STAGES];
   int inf_rn   [1:STAGES];
   int inf_load [1:STAGES];
   int ref_cnt;
   int exp_stall;
   int snap_cnt;
   logic [STAGES-1:0] snap_vld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_reset();
      for (int k = 1; k <= STAGES; k++) begin
         inf_valid[k] = 0; inf_wreg[k] = 0; inf_rn[k] = 0; inf_load[k] = 0;
      end
      ref_cnt = 0;
      exp_stall = 0;
   endtask

   // Drive ID fields at negedge, then compare every output with the reference.
   task automatic apply(input bit v, input int r0, input int r1, input bit [1:0] u,
                        input bit w, input int rn, input bit ld, input bit fl, input bit ex);
      logic [NSRC*SW-1:0] e_sel;
      logic [NSRC-1:0]    e_mem;
      logic [STAGES-1:0]  e_vld;
      int rs, haz;
      @(negedge clk);
      id_valid = v; id_rs = {AW'(r1), AW'(r0)}; id_use = u; id_wreg = w;
      id_rn = AW'(rn); id_load = ld; flush = fl; ext_stall = ex;
      #1;
      e_sel = '0; e_mem = '0; haz = 0;
      for (int s = 0; s < NSRC; s++) begin
         rs = (s == 0) ? r0 : r1;
         if (v && u[s] && rs != 0) begin
            for (int k = 1; k <= STAGES; k++) begin
               if (inf_valid[k] != 0 && inf_wreg[k] != 0 && inf_rn[k] == rs) begin
                  e_sel[s*SW +: SW] = SW'(k);
                  e_mem[s] = (inf_load[k] != 0);
                  if (inf_load[k] != 0 && k < LOAD_STAGE) haz = 1;
                  break;
               end
            end
         end
      end
      exp_stall = (haz != 0 && !fl) ? 1 : 0;
      for (int k = 1; k <= STAGES; k++) e_vld[k-1] = (inf_valid[k] != 0);
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("fwd_sel", 32'(fwd_sel), 32'(e_sel));
      chk("fwd_mem", 32'(fwd_mem), 32'(e_mem));
      chk("stg_valid", 32'(stg_valid), 32'(e_vld));
      chk("ret_valid", 32'(ret_valid),
          32'((inf_valid[STAGES] != 0 && inf_wreg[STAGES] != 0 && !ex) ? 1 : 0));
      chk("ret_rn", 32'(ret_rn), 32'(inf_rn[STAGES]));
      chk("stall_cnt", 32'(stall_cnt), 32'(ref_cnt));
      $display("step v=%0d rs=%0d/%0d use=%b w=%0d rn=%0d ld=%0d fl=%0d ex=%0d -> stall=%0d sel=%h mem=%b cnt=%0d",
               v, r0, r1, u, w, rn, ld, fl, ex, stall, fwd_sel, fwd_mem, stall_cnt);
   endtask

   // Advance the reference at the clock edge using the inputs applied this cycle.
   task automatic tick();
      @(posedge clk);
      if (clrn && !ext_stall) begin
         for (int k = STAGES; k >= 2; k--) begin
            inf_valid[k] = inf_valid[k-1]; inf_wreg[k] = inf_wreg[k-1];
            inf_rn[k] = inf_rn[k-1]; inf_load[k] = inf_load[k-1];
         end
         if (id_valid && exp_stall == 0 && !flush) begin
            inf_valid[1] = 1; inf_wreg[1] = id_wreg; inf_rn[1] = id_rn; inf_load[1] = id_load;
         end else begin
            inf_valid[1] = 0; inf_wreg[1] = 0; inf_rn[1] = 0; inf_load[1] = 0;
         end
         if (exp_stall != 0 && ref_cnt < 65535) ref_cnt++;
      end
   endtask

   initial begin
      clrn = 1'b0; id_valid = 0; id_rs = '0; id_use = '0; id_wreg = 0;
      id_rn = '0; id_load = 0; flush = 0; ext_stall = 0;
      ref_reset();
      repeat (2) @(posedge clk);
      apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      clrn = 1'b1;
      tick();

      // add $3, then both operands read $3
      apply(1, 0, 0, 2'b00, 1, 3, 0, 0, 0); tick();
      apply(1, 3, 3, 2'b11, 0, 0, 0, 0, 0);
      chk("add_fwd_sel", 32'(fwd_sel), 32'h5);
      tick();

      // lw $5 then a reader of $5: one stall, then forward from MEM
      apply(1, 0, 0, 2'b00, 1, 5, 1, 0, 0); tick();
      apply(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
      chk("lu_stall", 32'(stall), 32'h1);
      tick();
      apply(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
      chk("lu_fwd", 32'({stall, fwd_sel[1:0], fwd_mem[0]}), 32'b0101);
      chk("lu_cnt", 32'(stall_cnt), 32'h1);
      tick();

      // $7 in EXE and MEM: youngest wins; $0 never matches
      apply(1, 0, 0, 2'b00, 1, 7, 0, 0, 0); tick();
      apply(1, 0, 0, 2'b00, 1, 7, 0, 0, 0); tick();
      apply(1, 7, 0, 2'b01, 1, 0, 0, 0, 0);
      chk("young_sel", 32'(fwd_sel[1:0]), 32'h1);
      tick();
      apply(1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
      chk("r0_sel", 32'(fwd_sel), 32'h0);
      tick();

      // Load-use under ext_stall: frozen for three cycles, then one counted stall
      apply(1, 0, 0, 2'b00, 1, 5, 1, 0, 0); tick();
      snap_cnt = ref_cnt;
      snap_vld = stg_valid;
      for (int i = 0; i < 3; i++) begin
         apply(1, 5, 0, 2'b01, 0, 0, 0, 0, 1);
         chk("frz_vld", 32'(stg_valid), 32'(snap_vld));
         chk("frz_ret", 32'(ret_valid), 32'h0);
         tick();
      end
      apply(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
      chk("frz_cnt_hold", 32'(stall_cnt), 32'(snap_cnt));
      tick();
      apply(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
      chk("frz_cnt_one", 32'(stall_cnt), 32'(snap_cnt + 1));
      tick();

      // Flush masks the hazard and inserts a bubble
      apply(1, 0, 0, 2'b00, 1, 6, 1, 0, 0); tick();
      apply(1, 6, 0, 2'b01, 1, 9, 0, 1, 0);
      chk("fl_stall", 32'(stall), 32'h0);
      tick();
      apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("fl_bubble", 32'(stg_valid[0]), 32'h0);
      tick();

      // Asynchronous reset mid-cycle clears everything immediately
      apply(1, 0, 0, 2'b00, 1, 4, 1, 0, 0); tick();
      apply(1, 4, 0, 2'b01, 0, 0, 0, 0, 0);
      #2 clrn = 1'b0;
      #1;
      ref_reset();
      chk("rst_vld", 32'(stg_valid), 32'h0);
      chk("rst_cnt", 32'(stall_cnt), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_ret", 32'({ret_valid, ret_rn}), 32'h0);
      tick();
      apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      clrn = 1'b1;
      tick();

      // Random traffic over a small register window to provoke hits
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 6) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
